// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state encoding, frame width and peripheral register map
package spi_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;
  localparam int FRAME_W = 16;
  localparam logic [6:0] EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] PWM_DUTY    = 7'h04;
endpackage

// File: rtl/spi_ctrl_tick.sv
// spi_ctrl_tick: half-period down-counter, tick on the last cycle of each half-period
module spi_ctrl_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);
  localparam logic [7:0] TOP = 8'(CLK_DIV - 1);
  logic [7:0] cnt_q;
  assign tick = cnt_q == 8'd0;
  // reload on request or when a half-period completes, otherwise count down
  always_ff @(posedge clk)
    cnt_q <= (rst | reload | tick) ? TOP : cnt_q - 8'd1;
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator serialising 16-bit R/W+addr+data frames; SPI_CTRL_READ_EN adds read capture
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
`ifdef SPI_CTRL_READ_EN
  input  logic       cmd_write,
  input  logic       cipo,
  output logic [7:0] rd_data,
`endif
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);
  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be 2..255");
  end
  state_e state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [3:0] bit_q, bit_d;
  logic sclk_q, sclk_d, done_q, done_d, tick, fall, rise, last, wbit;
`ifdef SPI_CTRL_READ_EN
  assign wbit = cmd_write;
`else
  assign wbit = 1'b1;
`endif
  spi_ctrl_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .reload(state_q == IDLE),
    .tick(tick)
  );
  assign fall = state_q == SHIFT && tick && sclk_q;
  assign rise = state_q == SHIFT && tick && !sclk_q && bit_q != 4'd15;
  assign last = state_q == SHIFT && tick && !sclk_q && bit_q == 4'd15;
  // frame sequencing: latch at accept, shift on sclk falls, count rises
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bit_d = bit_q;
    sclk_d = sclk_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;
        sr_d = {wbit, cmd_addr, cmd_data};
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        sclk_d = 1'b1;
        bit_d = 4'd0;
      end
      SHIFT: begin
        sclk_d = fall ? 1'b0 : rise ? 1'b1 : sclk_q;
        sr_d = (fall && bit_q != 4'd15) ? {sr_q[FRAME_W-2:0], 1'b0} : sr_q;
        bit_d = rise ? bit_q + 4'd1 : bit_q;
        state_d = last ? GAP : SHIFT;
        done_d = last;
      end
      default: if (tick) state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_q <= 4'd0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      done_q <= done_d;
    end
`ifdef SPI_CTRL_READ_EN
  logic wr_q;
  logic [7:0] cap_q, rd_q;
  // capture cipo at rises 9..16 and publish it on the done cycle of read frames
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= 1'b1;
      cap_q <= 8'd0;
      rd_q <= 8'd0;
    end else begin
      if (state_q == IDLE && cmd_valid) wr_q <= cmd_write;
      if (rise && bit_q >= 4'd7) cap_q <= {cap_q[6:0], cipo};
      if (last && !wr_q) rd_q <= cap_q;
    end
  assign rd_data = rd_q;
`endif
  assign cmd_ready = state_q == IDLE;
  assign busy = !cmd_ready;
  assign done = done_q;
  assign ncs = !(state_q == SETUP || state_q == SHIFT);
  assign sclk = sclk_q;
  assign copi = !ncs && sr_q[FRAME_W-1];
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed checks of frame timing, handshake, abort and register loopback
module tb_spi_controller;
  import spi_ctrl_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_write, cipo, cmd_ready, busy, done, ncs, sclk, copi;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data, rd_data;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  spi_controller #(.CLK_DIV(D)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
`ifdef SPI_CTRL_READ_EN
    .cmd_write(cmd_write),
    .cipo(cipo),
    .rd_data(rd_data),
`endif
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .busy(busy),
    .done(done),
    .ncs(ncs),
    .sclk(sclk),
    .copi(copi)
  );
`ifndef SPI_CTRL_READ_EN
  assign rd_data = 8'd0;
`endif
  logic [15:0] psr;
  int pcnt;
  logic psclk;
  logic [7:0] pregs [0:127];
  always @(posedge clk)
    if (rst) begin
      pcnt <= 0;
      psclk <= 1'b0;
      for (int i = 0; i < 128; i++) pregs[i] <= 8'd0;
    end else begin
      psclk <= sclk;
      if (ncs) begin
        if (pcnt == 16 && psr[15]) pregs[psr[14:8]] <= psr[7:0];
        pcnt <= 0;
      end else if (sclk && !psclk) begin
        psr <= {psr[14:0], copi};
        pcnt <= pcnt + 1;
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_frame(input logic [6:0] a, input logic [7:0] d, input logic wr,
                           input bit scramble, input bit hold, input logic [7:0] rpat,
                           output logic [15:0] fr, output int low_n, output int rises,
                           output int done_at, output int ready_at, output int errs,
                           output int t_first, output int t_done, output logic [7:0] rd_done);
    logic prev;
    int m;
    logic exp_s;
    cmd_addr = a;
    cmd_data = d;
    cmd_write = wr;
    cmd_valid = 1'b1;
    errs = 0;
    for (int w = 0; w < 300 && !cmd_ready; w++) step();
    if (!cmd_ready) errs++;
    step();
    if (!hold) cmd_valid = 1'b0;
    t_first = cyc;
    t_done = 0;
    fr = 16'd0;
    low_n = 0;
    rises = 0;
    done_at = 0;
    ready_at = 0;
    rd_done = 8'd0;
    prev = 1'b0;
    for (int n = 1; n <= 300 && ready_at == 0; n++) begin
      if (scramble) begin
        cmd_addr = 7'($urandom);
        cmd_data = 8'($urandom);
      end
      m = n - 1;
      exp_s = m >= D && m < 33 * D && ((m / D) % 2 == 1);
      if (sclk !== exp_s) errs++;
      if (!ncs) low_n++;
      if (ncs && copi) errs++;
      if (sclk && !prev) begin
        rises++;
        fr = {fr[14:0], copi};
      end
      if (!sclk && rises >= 8 && rises <= 15) cipo = rpat[15 - rises];
      prev = sclk;
      if (done) begin
        if (done_at == 0) begin
          done_at = n;
          t_done = cyc;
          rd_done = rd_data;
        end else errs++;
      end
      if (cmd_ready) ready_at = n;
      else if (busy !== 1'b1) errs++;
      if (ready_at == 0) step();
    end
  endtask
  logic [15:0] fr;
  logic [7:0] rdd;
  int low_n, rises, done_at, ready_at, errs, t_first, t_done, t_done1, gap, dones;
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b1;
    cipo = 1'b0;
    cmd_addr = 7'd0;
    cmd_data = 8'd0;
    step();
    step();
    chk("rst_ncs", ncs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_copi", copi, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    run_frame(PWM_DUTY, 8'h80, 1'b1, 0, 0, 8'h00, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    chk("f1_frame", fr, 16'h8480);
    chk("f1_ncs_low", low_n, 132);
    chk("f1_rises", rises, 16);
    chk("f1_done_at", done_at, 133);
    chk("f1_ready_at", ready_at, 137);
    chk("f1_shape", errs, 0);
    run_frame(EN_OUT_7_0, 8'hFF, 1'b1, 0, 1, 8'h00, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    t_done1 = t_done;
    chk("b2b_frame1", fr, 16'h80FF);
    chk("b2b_shape1", errs, 0);
    run_frame(EN_PWM_7_0, 8'h0F, 1'b1, 0, 0, 8'h00, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    gap = t_first - t_done1;
    chk("b2b_frame2", fr, 16'h820F);
    chk("b2b_gap", gap, 5);
    chk("b2b_shape2", errs, 0);
    run_frame(7'h03, 8'h5A, 1'b1, 1, 0, 8'h00, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    chk("scr_frame", fr, 16'h835A);
    chk("scr_ready_at", ready_at, 137);
    chk("scr_shape", errs, 0);
    cmd_addr = 7'h05;
    cmd_data = 8'h33;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    rises = 0;
    for (int n = 0; n < 400 && rises < 7; n++) begin
      step();
      if (sclk && !psclk) rises++;
    end
    chk("abort_rises", rises, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ncs", ncs, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_copi", copi, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    dones = 0;
    for (int n = 0; n < 150; n++) begin
      step();
      if (done || !ncs) dones++;
    end
    chk("abort_quiet", dones, 0);
    run_frame(PWM_DUTY, 8'h80, 1'b1, 0, 0, 8'h00, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    chk("post_frame", fr, 16'h8480);
    chk("post_shape", errs, 0);
    run_frame(EN_OUT_7_0, 8'h01, 1'b1, 0, 0, 8'h00, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    step();
    chk("loop_duty", pregs[PWM_DUTY], 8'h80);
    chk("loop_en", pregs[EN_OUT_7_0], 8'h01);
    chk("loop_unused", pregs[7'h05], 8'h00);
`ifdef SPI_CTRL_READ_EN
    run_frame(EN_OUT_15_8, 8'h00, 1'b0, 0, 0, 8'hA5, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    chk("rd_frame", fr, 16'h0100);
    chk("rd_done_data", rdd, 8'hA5);
    chk("rd_shape", errs, 0);
    run_frame(EN_PWM_15_8, 8'h3C, 1'b1, 0, 0, 8'h5A, fr, low_n, rises, done_at, ready_at, errs, t_first, t_done, rdd);
    chk("wr_frame", fr, 16'h833C);
    chk("wr_keeps_rd", rd_data, 8'hA5);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
